// File: rtl/ahbl_master_arb.sv
// AHB-lite N-to-1 master arbiter with per-master address-phase hold registers.
// Define ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module ahbl_master_arb #(
    parameter int NUM_M = 2,
    parameter int AW    = 32,
    parameter int DW    = 64
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NUM_M*AW-1:0] HADDR_M,
    input  logic [NUM_M*2-1:0]  HTRANS_M,
    input  logic [NUM_M-1:0]    HWRITE_M,
    input  logic [NUM_M*3-1:0]  HSIZE_M,
    input  logic [NUM_M*DW-1:0] HWDATA_M,
    output logic [NUM_M-1:0]    HREADY_M,
    output logic [DW-1:0]       HRDATA_M,
    output logic [AW-1:0]       HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [DW-1:0]       HWDATA,
    input  logic                HREADY,
    input  logic [DW-1:0]       HRDATA
);
    localparam int IW = (NUM_M > 2) ? 2 : 1;

    logic [AW-1:0]    live_addr  [NUM_M];
    logic [1:0]       live_trans [NUM_M];
    logic [2:0]       live_size  [NUM_M];
    logic [DW-1:0]    live_wdata [NUM_M];

    logic [AW-1:0]    hold_addr  [NUM_M];
    logic [1:0]       hold_trans [NUM_M];
    logic [2:0]       hold_size  [NUM_M];
    logic [NUM_M-1:0] hold_write;
    logic [NUM_M-1:0] pending;

    logic [NUM_M-1:0] ready_m;
    logic [NUM_M-1:0] req;
    logic             gnt_vld;
    logic [IW-1:0]    gnt_idx;
    logic [AW-1:0]    gnt_addr;
    logic [1:0]       gnt_trans;
    logic             gnt_write;
    logic [2:0]       gnt_size;

    logic [IW-1:0]    owner_p1;
    logic             owner_vld_p1;
    logic [AW-1:0]    last_addr;
    logic [1:0]       last_trans;
    logic             last_write;
    logic [2:0]       last_size;
`ifdef ARB_RR_EN
    logic [IW-1:0]    ptr;
`endif

    for (genvar g = 0; g < NUM_M; g++) begin : g_unpack
        assign live_addr[g]  = HADDR_M[g*AW +: AW];
        assign live_trans[g] = HTRANS_M[g*2 +: 2];
        assign live_size[g]  = HSIZE_M[g*3 +: 3];
        assign live_wdata[g] = HWDATA_M[g*DW +: DW];
    end

    // A master only presents a fresh request while it sees its own ready high.
    always_comb begin
        ready_m = '1;
        req     = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (owner_vld_p1 && owner_p1 == IW'(i))
                ready_m[i] = HREADY;
            else if (pending[i])
                ready_m[i] = 1'b0;
            req[i] = pending[i] | (live_trans[i][1] & ready_m[i]);
        end
    end

    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_M; k++) begin
`ifdef ARB_RR_EN
            j = (int'(ptr) + k) % NUM_M;
`else
            j = k;
`endif
            if (!gnt_vld && req[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    always_comb begin
        if (pending[gnt_idx]) begin
            gnt_addr  = hold_addr[gnt_idx];
            gnt_trans = hold_trans[gnt_idx];
            gnt_write = hold_write[gnt_idx];
            gnt_size  = hold_size[gnt_idx];
        end else begin
            gnt_addr  = live_addr[gnt_idx];
            gnt_trans = live_trans[gnt_idx];
            gnt_write = HWRITE_M[gnt_idx];
            gnt_size  = live_size[gnt_idx];
        end
    end

    // Slave-side address phase: live winner when ready, frozen copy during waits.
    always_comb begin
        HADDR  = last_addr;
        HWRITE = last_write;
        HSIZE  = last_size;
        HTRANS = 2'b00;
        if (!HRESET) begin
            if (HREADY && gnt_vld) begin
                HADDR  = gnt_addr;
                HTRANS = gnt_trans;
                HWRITE = gnt_write;
                HSIZE  = gnt_size;
            end else if (!HREADY) begin
                HTRANS = last_trans;
            end
        end
    end

    assign HWDATA   = owner_vld_p1 ? live_wdata[owner_p1] : '0;
    assign HRDATA_M = HRDATA;
    assign HREADY_M = ready_m;

    // Address phase -> data phase boundary
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pending      <= '0;
            hold_write   <= '0;
            owner_vld_p1 <= 1'b0;
            owner_p1     <= '0;
            last_addr    <= '0;
            last_trans   <= 2'b00;
            last_write   <= 1'b0;
            last_size    <= 3'b000;
            for (int i = 0; i < NUM_M; i++) begin
                hold_addr[i]  <= '0;
                hold_trans[i] <= 2'b00;
                hold_size[i]  <= 3'b000;
            end
`ifdef ARB_RR_EN
            ptr          <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_M; i++) begin
                if (HREADY && gnt_vld && gnt_idx == IW'(i)) begin
                    pending[i] <= 1'b0;
                end else if (req[i] && !pending[i]) begin
                    pending[i]    <= 1'b1;
                    hold_addr[i]  <= live_addr[i];
                    hold_trans[i] <= live_trans[i];
                    hold_write[i] <= HWRITE_M[i];
                    hold_size[i]  <= live_size[i];
                end
            end
            if (HREADY) begin
                owner_vld_p1 <= gnt_vld;
                owner_p1     <= gnt_idx;
                if (gnt_vld) begin
                    last_addr  <= gnt_addr;
                    last_trans <= gnt_trans;
                    last_write <= gnt_write;
                    last_size  <= gnt_size;
`ifdef ARB_RR_EN
                    ptr        <= IW'((int'(gnt_idx) + 1) % NUM_M);
`endif
                end else begin
                    last_trans <= 2'b00;
                end
            end
        end
    end
endmodule

// File: tb/tb_ahbl_master_arb.sv
// Directed bench for ahbl_master_arb with four masters; checks use immediate assertions.
module tb_ahbl_master_arb;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM*AW-1:0]  haddr_m;
    logic [NM*2-1:0]   htrans_m;
    logic [NM-1:0]     hwrite_m;
    logic [NM*3-1:0]   hsize_m;
    logic [NM*DW-1:0]  hwdata_m;
    logic [NM-1:0]     hready_m;
    logic [DW-1:0]     hrdata_m;
    logic [AW-1:0]     haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DW-1:0]     hwdata;
    logic              hready;
    logic [DW-1:0]     hrdata;

    int checks = 0;
    int errors = 0;

    ahbl_master_arb #(.NUM_M(NM), .AW(AW), .DW(DW)) dut (
        .HCLK(clk), .HRESET(rst),
        .HADDR_M(haddr_m), .HTRANS_M(htrans_m), .HWRITE_M(hwrite_m),
        .HSIZE_M(hsize_m), .HWDATA_M(hwdata_m), .HREADY_M(hready_m),
        .HRDATA_M(hrdata_m), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic [1:0] t, input logic [31:0] a,
                         input logic w, input logic [63:0] d);
        htrans_m[i*2 +: 2]  = t;
        haddr_m[i*AW +: AW] = a;
        hwrite_m[i]         = w;
        hsize_m[i*3 +: 3]   = 3'b011;
        hwdata_m[i*DW +: DW] = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NM; i++) set_m(i, 2'b00, 32'h0, 1'b0, 64'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        idle_all();
        hready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_a;
        rst = 1'b1;
        hready = 1'b1;
        hrdata = '0;
        idle_all();
        #3;
        // Reset state, with a live request that must not leak onto the bus
        set_m(0, 2'b10, 32'h2000_0000, 1'b1, 64'h1);
        #1;
        check("rst_hready_m", hready_m, 4'hF);
        check("rst_htrans", htrans, 2'b00);
        check("rst_hwdata", hwdata, 64'h0);
        idle_all();
        step();
        rst = 1'b0;

        // Single uncontended master
        set_m(0, 2'b10, 32'h2000_0000, 1'b1, 64'h1111_2222_3333_4444);
        #1;
        check("a0_htrans", htrans, 2'b10);
        check("a0_haddr", haddr, 32'h2000_0000);
        check("a0_hsize", hsize, 3'b011);
        check("a0_hready_m0", hready_m[0], 1'b1);
        step();
        set_m(0, 2'b00, 32'h0, 1'b0, 64'h1111_2222_3333_4444);
        #1;
        check("a1_hwdata", hwdata, 64'h1111_2222_3333_4444);
        check("a1_hready_m", hready_m, 4'hF);
        check("a1_htrans_idle", htrans, 2'b00);
        check("a1_haddr_held", haddr, 32'h2000_0000);
        step();
        check("a2_hwdata_zero", hwdata, 64'h0);

        // Two simultaneous requests
        do_reset();
        set_m(0, 2'b10, 32'h4000_0000, 1'b0, 64'hAAAA);
        set_m(1, 2'b10, 32'h4000_0010, 1'b1, 64'hD1D1);
        #1;
        check("b0_haddr", haddr, 32'h4000_0000);
        check("b0_hwrite", hwrite, 1'b0);
        check("b0_hready_m", hready_m, 4'hF);
        step();
        set_m(0, 2'b00, 32'h0, 1'b0, 64'hAAAA);
        set_m(1, 2'b00, 32'hBAD0_0000, 1'b0, 64'hD1D1);
        #1;
        check("b1_hready_m1", hready_m[1], 1'b0);
        check("b1_haddr_hold", haddr, 32'h4000_0010);
        check("b1_htrans", htrans, 2'b10);
        check("b1_hwrite_hold", hwrite, 1'b1);
        check("b1_hwdata_m0", hwdata, 64'hAAAA);
        step();
        check("b2_hready_m1", hready_m[1], 1'b1);
        check("b2_hwdata_m1", hwdata, 64'hD1D1);
        check("b2_htrans", htrans, 2'b00);

        // Slave wait states while another master requests
        do_reset();
        set_m(0, 2'b10, 32'h5000_0000, 1'b1, 64'h55);
        #1;
        check("c0_haddr", haddr, 32'h5000_0000);
        step();
        set_m(0, 2'b00, 32'h0, 1'b0, 64'h55);
        set_m(1, 2'b10, 32'h6000_0020, 1'b0, 64'h0);
        hready = 1'b0;
        #1;
        check("c1_haddr", haddr, 32'h5000_0000);
        check("c1_htrans", htrans, 2'b10);
        check("c1_hready_m0", hready_m[0], 1'b0);
        check("c1_hready_m1", hready_m[1], 1'b1);
        step();
        check("c2_haddr", haddr, 32'h5000_0000);
        check("c2_hready_m1", hready_m[1], 1'b0);
        step();
        check("c3_haddr", haddr, 32'h5000_0000);
        check("c3_hready_m1", hready_m[1], 1'b0);
        step();
        hready = 1'b1;
        #1;
        check("c4_haddr", haddr, 32'h6000_0020);
        check("c4_hwrite", hwrite, 1'b0);
        check("c4_hready_m1", hready_m[1], 1'b0);
        check("c4_hwdata", hwdata, 64'h55);
        step();
        set_m(1, 2'b00, 32'h0, 1'b0, 64'h0);
        #1;
        check("c5_hready_m1", hready_m[1], 1'b1);
        check("c5_htrans", htrans, 2'b00);
        check("c5_haddr_held", haddr, 32'h6000_0020);

        // Continuous contention between masters 0 and 1
        do_reset();
        set_m(0, 2'b10, 32'h0000_0100, 1'b0, 64'h0);
        set_m(1, 2'b10, 32'h0000_0200, 1'b0, 64'h0);
        for (int k = 0; k < 8; k++) begin
`ifdef ARB_RR_EN
            exp_a = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
`else
            exp_a = 32'h0000_0100;
`endif
            #1;
            check($sformatf("d%0d_haddr", k), haddr, exp_a);
            step();
        end

        // Reset while pending and mid data phase
        do_reset();
        set_m(0, 2'b10, 32'h7000_0000, 1'b1, 64'h77);
        set_m(1, 2'b10, 32'h7000_0010, 1'b1, 64'h78);
        step();
        set_m(0, 2'b00, 32'h0, 1'b0, 64'h77);
        hready = 1'b0;
        #1;
        check("e1_hready_m", hready_m, 4'hC);
        rst = 1'b1;
        #1;
        check("e_rst_hready_m", hready_m, 4'hF);
        check("e_rst_htrans", htrans, 2'b00);
        check("e_rst_hwdata", hwdata, 64'h0);
        idle_all();
        step();
        rst = 1'b0;
        hready = 1'b1;
        #1;
        check("e_post_htrans", htrans, 2'b00);
        check("e_post_hready_m", hready_m, 4'hF);

        // All four masters at once
        do_reset();
        for (int i = 0; i < NM; i++) set_m(i, 2'b10, 32'h1000 + 32'(i) * 32'h10, 1'b0, 64'h0);
        #1;
        check("f0_haddr", haddr, 32'h1000);
        step();
        idle_all();
        #1;
        check("f1_haddr", haddr, 32'h1010);
        check("f1_hready_m", hready_m, 4'b0001);
        step();
        check("f2_haddr", haddr, 32'h1020);
        check("f2_hready_m", hready_m, 4'b0011);
        step();
        hrdata = 64'hDEAD_BEEF_0000_0001;
        #1;
        check("f3_haddr", haddr, 32'h1030);
        check("f3_hready_m", hready_m, 4'b0111);
        check("f3_hrdata_m", hrdata_m, 64'hDEAD_BEEF_0000_0001);
        step();
        check("f4_htrans", htrans, 2'b00);
        check("f4_hready_m", hready_m, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahbl_master_arb.md
AHBL_MASTER_ARB -- requirements
Module: ahbl_master_arb

Interface
REQ-001 SHALL have parameter NUM_M, 2, number of AHB-lite masters (legal 2..4).
REQ-002 SHALL have parameter AW, 32, address width.
REQ-003 SHALL have parameter DW, 64, data width.
REQ-004 SHALL have port HCLK  in  1  single clock for all logic.
REQ-005 SHALL have port HRESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port HADDR_M  in  NUM_M*AW  master address buses; master i occupies slice [i*AW +: AW].
REQ-007 SHALL have port HTRANS_M  in  NUM_M*2  master transfer types.
REQ-008 SHALL have port HWRITE_M  in  NUM_M  master write flags.
REQ-009 SHALL have port HSIZE_M  in  NUM_M*3  master transfer sizes.
REQ-010 SHALL have port HWDATA_M  in  NUM_M*DW  master write data.
REQ-011 SHALL have port HREADY_M  out  NUM_M  per-master ready.
REQ-012 SHALL have port HRDATA_M  out  DW  read data, broadcast to all masters.
REQ-013 SHALL have port HADDR  out  AW  slave-side address.
REQ-014 SHALL have port HTRANS  out  2  slave-side transfer type.
REQ-015 SHALL have port HWRITE  out  1  slave-side write flag.
REQ-016 SHALL have port HSIZE  out  3  slave-side size.
REQ-017 SHALL have port HWDATA  out  DW  slave-side write data.
REQ-018 SHALL have port HREADY  in  1  slave-side ready.
REQ-019 SHALL have port HRDATA  in  DW  slave-side read data.

Function
REQ-020 SHALL treat master i as requesting when pending[i]=1, or when HTRANS_M[i][1]=1 and HREADY_M[i]=1.
REQ-021 SHALL arbitrate only in cycles where HREADY=1; in these cycles the winner's address-phase signals SHALL drive HADDR/HTRANS/HWRITE/HSIZE.
REQ-022 SHALL source a winner's address phase from its hold register when pending[i]=1, else from its live inputs.
REQ-023 SHALL capture the address phase (HADDR, HTRANS, HWRITE, HSIZE) of each requesting non-winner into hold register i, set pending[i], and drive HREADY_M[i]=0 from the next cycle.
REQ-024 SHALL clear pending[i] on the HREADY=1 edge at which the held transfer is granted.
REQ-025 SHALL record data-phase owner (owner index, valid) on every HREADY=1 edge; valid=1 only if a transfer was issued.
REQ-026 SHALL drive HWDATA from HWDATA_M of the data-phase owner; if no owner, drive zero.
REQ-027 SHALL drive HREADY_M[i] as follows: HREADY while i owns the data phase; 0 while pending[i]=1; 1 otherwise.
REQ-028 SHALL drive HTRANS=IDLE (00) when no master requests; HADDR/HWRITE/HSIZE then hold the last issued values.
REQ-029 SHALL, while HREADY=0, hold all slave-side address-phase outputs stable and capture new master requests into hold registers without granting.
REQ-030 SHALL allow a master to be granted on consecutive transfers (pipelined) when no other master requests.
REQ-031 SHALL add zero cycles of latency for an uncontended master: combinational address-phase path, no bubble.
REQ-032 SHALL never lose a request: each pending[i] is served within NUM_M grants under round-robin.

Reset
REQ-033 SHALL, while HRESET=1, clear pending[], hold registers, owner valid and the round-robin pointer (to 0), and drive HREADY_M=all-ones, HTRANS=00, HWDATA=0.
REQ-034 SHALL abandon in-flight and pending transfers on mid-operation reset; there is no replay after reset.

Configuration
REQ-035 SHALL support macro ARB_RR_EN: when defined, arbitration is round-robin and search starts at (last grantee + 1) mod NUM_M; when undefined, arbitration is fixed priority with the lowest index winning and no pointer register.

Verification
REQ-036 Single master 0 issues NONSEQ write 0x2000_0000, other masters idle -> HTRANS=10 in the same cycle, HWDATA from master 0 next cycle, HREADY_M[0] never low.
REQ-037 Masters 0 and 1 issue NONSEQ in the same cycle (ARB_RR_EN, pointer=0) -> master 0 goes first; master 1 is held with HREADY_M[1]=0 for 1 cycle, then issued from the hold register with the captured address 0x4000_0010.
REQ-038 Slave inserts 3 wait states (HREADY=0) while master 1 requests -> slave-side address stable for 3 cycles; master 1 captured; granted on the first HREADY=1.
REQ-039 Both masters request continuously for 8 transfers, ARB_RR_EN -> grants alternate 0,1,0,1...; without the macro, master 0 wins all transfers while it continues to request.
REQ-040 HRESET asserted while pending[1]=1 and master 0 is mid-data-phase -> next cycle HREADY_M=11, HTRANS=00, pending=0.
REQ-041 NUM_M=4, all four request at once, ARB_RR_EN -> grant order 0,1,2,3, each served within 4 HREADY edges, read data 0xDEAD_BEEF_0000_0001 seen on HRDATA_M during master 2's data phase.
